gpr_wb_buffer: RTL and testbench

Write-side feeder for the GPR file in the PCOCD core.
- Queues register writes and flag updates from producers: the load unit and multi-cycle execute units.
- Drains one entry per cycle into the GPR's single write port (WE/AWr/Din/FlagOp/NFlag).
- Supplies read-bypass values, so decode sees pending writes that the GPR has not yet committed.

---
 rtl/gpr_wb_buffer_pkg.sv | 38 +++
 rtl/gpr_wb_buffer_wb_fifo.sv | 65 ++++++
 rtl/gpr_wb_buffer.sv | 141 ++++++++++++++
 tb/tb_gpr_wb_buffer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/gpr_wb_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gpr_wb_buffer_pkg                                                        |
// | Shared GPR write-back constants, queue entry layout and bypass helper.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package gpr_wb_buffer_pkg;

  localparam logic [4:0] REG_ADDR_FLAG      = 5'd31;
  localparam logic [1:0] FLAG_OP_DIS        = 2'd0;
  localparam logic [1:0] FLAG_OP_SET        = 2'd1;
  localparam logic [1:0] FLAG_OP_SET_AND_WR = 2'd2;
  localparam int         WB_ENTRY_W         = 1 + 1 + 5 + 32 + 32;

  typedef struct packed {
    logic        we;
    logic        flag;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] nflag;
  } wb_entry_t;

  // {hit, data} for one entry; the flag write lands after Din, so nflag wins.
  function automatic logic [32:0] byp_match(input wb_entry_t e, input logic [4:0] a,
                                            input logic vld);
    logic [32:0] r;
    r = '0;
    if (vld) begin
      if (e.flag && (a == REG_ADDR_FLAG))
        r = {1'b1, e.nflag};
      else if (e.we && (e.addr == a) && (a != 5'd0))
        r = {1'b1, e.data};
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpr_wb_buffer_wb_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gpr_wb_buffer_wb_fifo                                                    |
// | Circular entry storage with per-entry valid bits, pointers and count.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gpr_wb_buffer_wb_fifo
  import gpr_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             merge,
  input  logic             pop,
  input  wb_entry_t        push_entry,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic [PTR_W-1:0] head_ptr,
  output wb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] valid
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   cnt;
  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] tail_ptr;

  assign tail_ptr = wr_ptr - PTR_W'(1);
  assign full     = (cnt == (PTR_W+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign entries  = mem;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_ptr <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      valid    <= '0;
    end else begin
      if (pop) begin
        valid[head_ptr] <= 1'b0;
        head_ptr        <= head_ptr + PTR_W'(1);
      end
      if (push) begin
        mem[wr_ptr]   <= push_entry;
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (merge)
        mem[tail_ptr].data <= push_entry.data;
      case ({push, pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpr_wb_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gpr_wb_buffer                                                            |
// | GPR write-back queue: drains into the GPR write port, supplies bypass.   |
// | Optional macro GPR_WB_COALESCE_EN merges same-register writes at tail.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gpr_wb_buffer
  import gpr_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic             push_we,
  input  logic [4:0]       push_addr,
  input  logic [31:0]      push_data,
  input  logic             push_flag,
  input  logic [31:0]      push_nflag,
  input  logic             drain_en,
  output logic             gpr_we,
  output logic [4:0]       gpr_awr,
  output logic [31:0]      gpr_din,
  output logic [1:0]       gpr_flagop,
  output logic [31:0]      gpr_nflag,
  input  logic [4:0]       byp_a1,
  input  logic [4:0]       byp_a2,
  output logic             byp_hit1,
  output logic             byp_hit2,
  output logic [31:0]      byp_data1,
  output logic [31:0]      byp_data2,
  output logic [PTR_W:0]   count
);

  logic             full;
  logic             empty;
  logic [PTR_W-1:0] head_ptr;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  wb_entry_t        new_entry;
  wb_entry_t        head;
  logic             accept;
  logic             store;
  logic             merge;
  logic             alloc;
  logic             pop;

  assign push_ready = !full;
  assign accept     = push_valid && push_ready;
  assign pop        = drain_en && !empty;

  // Writes to r0 are discarded; an entry left with nothing to do is dropped.
  assign new_entry.we    = push_we && (push_addr != 5'd0);
  assign new_entry.flag  = push_flag;
  assign new_entry.addr  = push_addr;
  assign new_entry.data  = push_data;
  assign new_entry.nflag = push_nflag;
  assign store           = accept && (new_entry.we || push_flag);

`ifdef GPR_WB_COALESCE_EN
  logic [PTR_W-1:0] tail_idx;
  wb_entry_t        tail;
  assign tail_idx = head_ptr + count[PTR_W-1:0] - PTR_W'(1);
  assign tail     = entries[tail_idx];
  assign merge    = store && new_entry.we && !push_flag && !empty && valid[tail_idx] &&
                    tail.we && !tail.flag && (tail.addr == push_addr) &&
                    !(pop && (count == (PTR_W+1)'(1)));
`else
  assign merge = 1'b0;
`endif

  assign alloc = store && !merge;

  gpr_wb_buffer_wb_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (alloc),
    .merge      (merge),
    .pop        (pop),
    .push_entry (new_entry),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .head_ptr   (head_ptr),
    .entries    (entries),
    .valid      (valid)
  );

  assign head = entries[head_ptr];

  always_comb begin
    gpr_we     = 1'b0;
    gpr_flagop = FLAG_OP_DIS;
    gpr_awr    = '0;
    gpr_din    = '0;
    gpr_nflag  = '0;
    if (pop) begin
      gpr_we    = head.we;
      gpr_awr   = head.addr;
      gpr_din   = head.data;
      gpr_nflag = head.nflag;
      if (head.flag)
        gpr_flagop = head.we ? FLAG_OP_SET_AND_WR : FLAG_OP_SET;
    end
  end

  logic [32:0]      r1;
  logic [32:0]      r2;
  logic [32:0]      m1;
  logic [32:0]      m2;
  logic [PTR_W-1:0] idx;

  // Scan oldest to youngest so the last hit is the youngest pending value.
  always_comb begin
    r1  = '0;
    r2  = '0;
    m1  = '0;
    m2  = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PTR_W'(i);
      m1  = byp_match(entries[idx], byp_a1, valid[idx]);
      m2  = byp_match(entries[idx], byp_a2, valid[idx]);
      if (m1[32]) r1 = m1;
      if (m2[32]) r2 = m2;
    end
  end

  assign byp_hit1  = r1[32];
  assign byp_data1 = r1[31:0];
  assign byp_hit2  = r2[32];
  assign byp_data2 = r2[31:0];

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gpr_wb_buffer                                                         |
// | Randomized and directed bench against a queue-based reference model.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_gpr_wb_buffer;
  import gpr_wb_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n = 1'b0;
  logic             push_valid = 1'b0, push_we = 1'b0, push_flag = 1'b0, drain_en = 1'b0;
  logic [4:0]       push_addr = '0, byp_a1 = '0, byp_a2 = '0;
  logic [31:0]      push_data = '0, push_nflag = '0;
  logic             push_ready, gpr_we, byp_hit1, byp_hit2;
  logic [4:0]       gpr_awr;
  logic [31:0]      gpr_din, gpr_nflag, byp_data1, byp_data2;
  logic [1:0]       gpr_flagop;
  logic [PTR_W:0]   count;

  gpr_wb_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset_n(reset_n), .push_valid(push_valid), .push_ready(push_ready),
    .push_we(push_we), .push_addr(push_addr), .push_data(push_data),
    .push_flag(push_flag), .push_nflag(push_nflag), .drain_en(drain_en),
    .gpr_we(gpr_we), .gpr_awr(gpr_awr), .gpr_din(gpr_din), .gpr_flagop(gpr_flagop),
    .gpr_nflag(gpr_nflag), .byp_a1(byp_a1), .byp_a2(byp_a2), .byp_hit1(byp_hit1),
    .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2), .count(count)
  );

  typedef struct {
    logic        we;
    logic        flag;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] nflag;
  } ref_t;

  ref_t q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Youngest pending write to register a, flag update counting as a write to the flag register.
  function automatic logic [32:0] byp_ref(input logic [4:0] a);
    logic [32:0] r;
    r = '0;
    foreach (q[i]) begin
      if (q[i].flag && a == REG_ADDR_FLAG)            r = {1'b1, q[i].nflag};
      else if (q[i].we && q[i].addr == a && a != 0)   r = {1'b1, q[i].data};
    end
    return r;
  endfunction

  task automatic compare_all();
    logic [32:0] b1, b2;
    logic        busy;
    ref_t        h;
    logic        e_we;
    logic [1:0]  e_op;
    logic [31:0] e_nf;
    busy = drain_en && q.size() > 0;
    e_we = 1'b0; e_op = FLAG_OP_DIS; e_nf = '0;
    if (busy) begin
      h    = q[0];
      e_we = h.we;
      e_nf = h.nflag;
      if (h.flag) e_op = h.we ? FLAG_OP_SET_AND_WR : FLAG_OP_SET;
    end
    chk("push_ready", push_ready, q.size() < DEPTH);
    chk("count", count, q.size());
    chk("gpr_we", gpr_we, e_we);
    chk("gpr_flagop", gpr_flagop, e_op);
    chk("gpr_nflag", gpr_nflag, e_nf);
    if (!busy) begin
      chk("gpr_awr_idle", gpr_awr, 0);
      chk("gpr_din_idle", gpr_din, 0);
    end else if (h.we) begin
      chk("gpr_awr", gpr_awr, h.addr);
      chk("gpr_din", gpr_din, h.data);
    end
    b1 = byp_ref(byp_a1);
    b2 = byp_ref(byp_a2);
    chk("byp1", {byp_hit1, byp_data1}, b1);
    chk("byp2", {byp_hit2, byp_data2}, b2);
  endtask

  task automatic model_update();
    logic pop, weff, mrg;
    ref_t e;
    if (!reset_n) begin
      q.delete();
      return;
    end
    pop  = drain_en && q.size() > 0;
    weff = push_we && push_addr != 0;
    if (push_valid && q.size() < DEPTH && (weff || push_flag)) begin
      mrg = 1'b0;
`ifdef GPR_WB_COALESCE_EN
      if (weff && !push_flag && q.size() > 0 && q[$].we && !q[$].flag &&
          q[$].addr == push_addr && !(pop && q.size() == 1))
        mrg = 1'b1;
`endif
      if (mrg) q[$].data = push_data;
      else begin
        e.we = weff; e.flag = push_flag; e.addr = push_addr;
        e.data = push_data; e.nflag = push_nflag;
        q.push_back(e);
      end
    end
    if (pop) void'(q.pop_front());
  endtask

  task automatic cycle(input logic rn, input logic pv, input logic pwe, input logic [4:0] pa,
                       input logic [31:0] pd, input logic pf, input logic [31:0] pn,
                       input logic de, input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    reset_n = rn; push_valid = pv; push_we = pwe; push_addr = pa; push_data = pd;
    push_flag = pf; push_nflag = pn; drain_en = de; byp_a1 = a1; byp_a2 = a2;
    #1 compare_all();
    @(posedge clk);
    model_update();
  endtask

  function automatic logic [4:0] rnd_addr();
    case ($urandom_range(0, 5))
      0: return 5'd0;
      1: return REG_ADDR_FLAG;
      2: return 5'd1;
      3: return 5'd2;
      4: return 5'd3;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    int exp_cnt;
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // fill to 3 then reset with a push on the reset edge
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 5'(i + 1), 32'(i + 100), 0, 0, 0, 5'd1, 5'd2);
    cycle(0, 1, 1, 5'd4, 32'h55, 0, 0, 0, 5'd1, 5'd4);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd4);
    chk("rst_count", count, 0);
    chk("rst_hit1", byp_hit1, 0);
    // single push then drain
    cycle(1, 1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 1, 5'd5, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0);
    chk("dir_din", gpr_din, 32'hDEADBEEF);
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("dir_empty", count, 0);
    // two writes to r8 held
    cycle(1, 1, 1, 5'd8, 32'd1, 0, 0, 0, 5'd8, 0);
    cycle(1, 1, 1, 5'd8, 32'd2, 0, 0, 0, 5'd8, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 5'd8, 0);
`ifdef GPR_WB_COALESCE_EN
    exp_cnt = 1;
`else
    exp_cnt = 2;
`endif
    chk("dir_r8_data", byp_data1, 32'd2);
    chk("dir_r8_count", count, exp_cnt);
    repeat (3) cycle(1, 0, 0, 0, 0, 0, 0, 1, 5'd8, 0);
    // write plus flag update on the flag register
    cycle(1, 1, 1, REG_ADDR_FLAG, 32'h11, 1, 32'h22, 0, REG_ADDR_FLAG, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 1, REG_ADDR_FLAG, 0);
    chk("dir_flag_byp", byp_data1, 32'h22);
    chk("dir_flag_op", gpr_flagop, FLAG_OP_SET_AND_WR);
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // fill, reject fifth, drain across wrap while pushing
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 5'(i + 10), 32'(i + 200), 0, 0, 0, 5'd10, 5'd14);
    chk("dir_full_ready", push_ready, 0);
    for (int i = 0; i < 8; i++) cycle(1, 1, 1, 5'(i + 20), 32'(i + 300), 0, 0, 1, 5'd20, 5'd11);
    repeat (5) cycle(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // r0 writes
    cycle(1, 1, 1, 5'd0, 32'h9, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 5'd0, 32'h9, 1, 32'd7, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("dir_set_op", gpr_flagop, FLAG_OP_SET);
    chk("dir_set_nflag", gpr_nflag, 32'd7);
    // random traffic
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) != 0,
            rnd_addr(), $urandom, $urandom_range(0, 3) == 0, $urandom,
            $urandom_range(0, 2) != 0, rnd_addr(), rnd_addr());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
